// File: rtl/alu_issue_queue.sv
// alu_issue_queue: feeder stage in front of the 16-bit ALU.
//
// Buffers instruction words from fetch in a DEPTH-entry FIFO. Each popped word is
// driven onto the ALU `inp` bus from a posedge register, so the ALU can sample it
// on the following negedge. Multi-cycle type-A ops (mul, div/mod, rotates) are held
// on the bus for MC_CYCLES cycles before the next word may issue. NOP_WORD is
// driven whenever nothing is issuing.
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset
//   flush        drop queued words and any in-flight hold (issue_count kept)
//   in_valid     upstream word valid
//   in_instr     upstream instruction word
//   in_ready     queue can accept (not full), from registered state only
//   alu_inp      registered word to the ALU
//   alu_valid    one-cycle strobe when a new real word first appears on alu_inp
//   busy         multi-cycle hold in progress
//   occupancy    FIFO entry count
//   issue_count  number of real words issued, wrapping
//   illegal      one-cycle pulse when an illegal word is dropped
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN
//   When defined, type-A words with an undefined opcode are dropped at pop time
//   and flagged on `illegal`. When undefined, `illegal` stays 0 and every word is
//   forwarded unchanged.

module alu_issue_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MC_CYCLES = 2,
  parameter logic [15:0] NOP_WORD  = 16'h000C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  output logic                     in_ready,
  output logic [15:0]              alu_inp,
  output logic                     alu_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              issue_count,
  output logic                     illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [PtrW:0]   Full     = (PtrW + 1)'(DEPTH);
  localparam logic [CntW-1:0] HoldInit = CntW'(MC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  logic [15:0]     mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  state_e          state_q;
  logic [CntW-1:0] hold_q;
  logic [15:0]     alu_inp_q;
  logic            alu_valid_q;
  logic            busy_q;
  logic [15:0]     issue_count_q;
  logic            illegal_q;

  logic [15:0] head;
  logic        do_push, do_pop, head_mc, head_bad;

  assign head     = mem[rptr_q];
  assign in_ready = (count_q != Full);
  assign do_push  = in_valid && in_ready;
  // A hold releases on the edge after its counter has reached zero.
  assign do_pop   = (count_q != '0) && ((state_q != StHold) || (hold_q == '0));
  assign head_mc  = (head[15:14] == 2'b00) &&
                    (head[3:0] inside {4'b0001, 4'b0010, 4'b1000, 4'b1001});

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign head_bad = (head[15:14] == 2'b00) &&
                    !(head[3:0] inside {4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b0001,
                                        4'b0010, 4'b1010, 4'b1011, 4'b1000, 4'b1001});
`else
  assign head_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      hold_q        <= '0;
      alu_inp_q     <= NOP_WORD;
      alu_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      issue_count_q <= '0;
      illegal_q     <= 1'b0;
    end else if (flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      hold_q      <= '0;
      alu_inp_q   <= NOP_WORD;
      alu_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      alu_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (do_push) begin
        mem[wptr_q] <= in_instr;
        wptr_q      <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);

      if (do_pop) begin
        if (head_bad) begin
          // Dropped word: bus shows NOP, next word may pop on the next edge.
          alu_inp_q <= NOP_WORD;
          illegal_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIssue;
        end else begin
          alu_inp_q     <= head;
          alu_valid_q   <= 1'b1;
          issue_count_q <= issue_count_q + 16'd1;
          if (head_mc && (MC_CYCLES > 1)) begin
            state_q <= StHold;
            hold_q  <= HoldInit;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIssue;
            busy_q  <= 1'b0;
          end
        end
      end else if ((state_q == StHold) && (hold_q != '0)) begin
        hold_q <= hold_q - 1'b1;
      end else begin
        // Nothing to issue: park on NOP.
        alu_inp_q <= NOP_WORD;
        busy_q    <= 1'b0;
        state_q   <= StIdle;
      end
    end
  end

  assign alu_inp     = alu_inp_q;
  assign alu_valid   = alu_valid_q;
  assign busy        = busy_q;
  assign occupancy   = count_q;
  assign issue_count = issue_count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue. Two instances share the stimulus: dut_a uses the
// default MC_CYCLES=2, dut_b uses MC_CYCLES=8 so the queue can be filled while a
// long hold blocks pops. Issued words are matched against per-instance scoreboards.

module tb_alu_issue_queue;

  localparam logic [15:0] Nop = 16'h000C;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [15:0] in_instr;

  logic        a_ready, a_valid, a_busy, a_illegal;
  logic [15:0] a_inp, a_cnt;
  logic [2:0]  a_occ;
  logic        b_ready, b_valid, b_busy, b_illegal;
  logic [15:0] b_inp, b_cnt;
  logic [2:0]  b_occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .MC_CYCLES(2), .NOP_WORD(16'h000C)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(a_ready), .alu_inp(a_inp), .alu_valid(a_valid), .busy(a_busy),
    .occupancy(a_occ), .issue_count(a_cnt), .illegal(a_illegal)
  );

  alu_issue_queue #(.DEPTH(4), .MC_CYCLES(8), .NOP_WORD(16'h000C)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(b_ready), .alu_inp(b_inp), .alu_valid(b_valid), .busy(b_busy),
    .occupancy(b_occ), .issue_count(b_cnt), .illegal(b_illegal)
  );

  // Drive one cycle of inputs, then return 1 time unit after the posedge.
  task automatic step(input logic v, input logic [15:0] w, input logic f);
    in_valid = v;
    in_instr = w;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    sb_a.delete();
    sb_b.delete();
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (a_inp !== Nop) begin n_fail++;
      $display("FAIL reset_inp: got %h want %h", a_inp, Nop); end
    n_checks++; if (a_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", a_valid); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b want 1", a_ready); end
    n_checks++; if (a_occ !== 3'd0) begin n_fail++;
      $display("FAIL reset_occ: got %0d want 0", a_occ); end
    n_checks++; if (a_cnt !== 16'd0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    n_checks++; if ({a_busy, a_illegal, b_busy, b_illegal} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {a_busy, a_illegal, b_busy, b_illegal}); end
    n_checks++; if (b_inp !== Nop) begin n_fail++;
      $display("FAIL reset_inp_b: got %h want %h", b_inp, Nop); end
  endtask

  task automatic test_single_issue();
    logic [15:0] exp;
    do_reset();
    sb_a.push_back(16'h034F);
    step(1'b1, 16'h034F, 1'b0);
    n_checks++; if (a_valid !== 1'b0 || a_inp !== Nop) begin n_fail++;
      $display("FAIL single_lat: got %b/%h want 0/%h", a_valid, a_inp, Nop); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (a_valid !== 1'b1) begin n_fail++;
      $display("FAIL single_valid: got %b want 1", a_valid); end
    exp = sb_a.pop_front();
    n_checks++; if (a_inp !== exp) begin n_fail++;
      $display("FAIL single_word: got %h want %h", a_inp, exp); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (a_inp !== Nop || a_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_nop: got %h/%b want %h/0", a_inp, a_valid, Nop); end
    n_checks++; if (a_cnt !== 16'd1) begin n_fail++;
      $display("FAIL single_cnt: got %0d want 1", a_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    sb_a.push_back(16'h0321);
    step(1'b1, 16'h0321, 1'b0);
    sb_a.push_back(16'h012F);
    step(1'b1, 16'h012F, 1'b0);
    exp = sb_a.pop_front();
    n_checks++; if (a_inp !== exp || a_valid !== 1'b1 || a_busy !== 1'b1) begin n_fail++;
      $display("FAIL b2b_c1: got %h/%b/%b want %h/1/1", a_inp, a_valid, a_busy, exp); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (a_inp !== exp || a_valid !== 1'b0 || a_busy !== 1'b1) begin n_fail++;
      $display("FAIL b2b_c2: got %h/%b/%b want %h/0/1", a_inp, a_valid, a_busy, exp); end
    step(1'b0, 16'h0, 1'b0);
    exp = sb_a.pop_front();
    n_checks++; if (a_inp !== exp || a_valid !== 1'b1 || a_busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_c3: got %h/%b/%b want %h/1/0", a_inp, a_valid, a_busy, exp); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (a_inp !== Nop || a_cnt !== 16'd2) begin n_fail++;
      $display("FAIL b2b_end: got %h/%0d want %h/2", a_inp, a_cnt, Nop); end
  endtask

  task automatic test_full_and_drain();
    logic [15:0] words [4];
    logic [15:0] exp;
    words[0] = 16'h034F; words[1] = 16'h4123; words[2] = 16'h8456; words[3] = 16'hC789;
    do_reset();
    sb_b.push_back(16'h0002);
    step(1'b1, 16'h0002, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sb_b.push_back(words[i]);
      step(1'b1, words[i], 1'b0);
      if (b_valid) begin
        exp = sb_b.pop_front();
        n_checks++; if (b_inp !== exp) begin n_fail++;
          $display("FAIL fill_issue: got %h want %h", b_inp, exp); end
      end
    end
    n_checks++; if (b_occ !== 3'd4 || b_ready !== 1'b0) begin n_fail++;
      $display("FAIL full: got occ %0d ready %b want 4/0", b_occ, b_ready); end
    step(1'b1, 16'h1111, 1'b0);
    n_checks++; if (b_occ !== 3'd4 || b_busy !== 1'b1 || b_valid !== 1'b0) begin n_fail++;
      $display("FAIL full_ignore: got occ %0d busy %b valid %b want 4/1/0",
               b_occ, b_busy, b_valid); end
    for (int c = 0; c < 40 && sb_b.size() > 0; c++) begin
      step(1'b0, 16'h0, 1'b0);
      if (b_valid) begin
        exp = sb_b.pop_front();
        n_checks++; if (b_inp !== exp) begin n_fail++;
          $display("FAIL drain_order: got %h want %h", b_inp, exp); end
      end
    end
    n_checks++; if (sb_b.size() != 0) begin n_fail++;
      $display("FAIL drain_timeout: got %0d left want 0", sb_b.size()); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (b_inp !== Nop || b_cnt !== 16'd5 || b_occ !== 3'd0) begin n_fail++;
      $display("FAIL drain_end: got %h/%0d/%0d want %h/5/0", b_inp, b_cnt, b_occ, Nop); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 16'h0002, 1'b0);
    step(1'b1, 16'h4111, 1'b0);
    step(1'b1, 16'h4222, 1'b0);
    step(1'b1, 16'h4333, 1'b0);
    n_checks++; if (b_occ !== 3'd3 || b_busy !== 1'b1) begin n_fail++;
      $display("FAIL pre_flush: got occ %0d busy %b want 3/1", b_occ, b_busy); end
    step(1'b1, 16'h4444, 1'b1);
    n_checks++; if (b_occ !== 3'd0 || b_busy !== 1'b0) begin n_fail++;
      $display("FAIL flush_state: got occ %0d busy %b want 0/0", b_occ, b_busy); end
    n_checks++; if (b_inp !== Nop || b_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_bus: got %h/%b want %h/0", b_inp, b_valid, Nop); end
    n_checks++; if (b_cnt !== 16'd1 || b_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_cnt: got %0d/%b want 1/1", b_cnt, b_ready); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (b_valid !== 1'b0 || b_inp !== Nop || b_occ !== 3'd0) begin n_fail++;
      $display("FAIL flush_push: got %b/%h/%0d want 0/%h/0", b_valid, b_inp, b_occ, Nop); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    step(1'b1, 16'h0002, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (b_busy !== 1'b1 || b_inp !== 16'h0002) begin n_fail++;
      $display("FAIL hold_pre_rst: got %b/%h want 1/0002", b_busy, b_inp); end
    do_reset();
    n_checks++; if (b_busy !== 1'b0 || b_inp !== Nop || b_cnt !== 16'd0) begin n_fail++;
      $display("FAIL hold_rst: got %b/%h/%0d want 0/%h/0", b_busy, b_inp, b_cnt, Nop); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++; if (b_valid !== 1'b0 || b_inp !== Nop) begin n_fail++;
      $display("FAIL hold_rst_after: got %b/%h want 0/%h", b_valid, b_inp, Nop); end
  endtask

  task automatic test_illegal();
    logic [15:0] exp;
    do_reset();
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    step(1'b1, 16'h0005, 1'b0);
    sb_a.push_back(16'h4000);
    step(1'b1, 16'h4000, 1'b0);
    n_checks++; if (a_illegal !== 1'b1 || a_inp !== Nop || a_valid !== 1'b0) begin n_fail++;
      $display("FAIL illegal_drop: got %b/%h/%b want 1/%h/0", a_illegal, a_inp, a_valid, Nop); end
    step(1'b0, 16'h0, 1'b0);
    exp = sb_a.pop_front();
    n_checks++; if (a_illegal !== 1'b0 || a_valid !== 1'b1 || a_inp !== exp) begin n_fail++;
      $display("FAIL illegal_next: got %b/%b/%h want 0/1/%h", a_illegal, a_valid, a_inp, exp); end
    n_checks++; if (a_cnt !== 16'd1) begin n_fail++;
      $display("FAIL illegal_cnt: got %0d want 1", a_cnt); end
`else
    sb_a.push_back(16'h0005);
    step(1'b1, 16'h0005, 1'b0);
    sb_a.push_back(16'h4000);
    step(1'b1, 16'h4000, 1'b0);
    exp = sb_a.pop_front();
    n_checks++; if (a_illegal !== 1'b0 || a_valid !== 1'b1 || a_inp !== exp) begin n_fail++;
      $display("FAIL noillegal_fwd: got %b/%b/%h want 0/1/%h", a_illegal, a_valid, a_inp, exp); end
    step(1'b0, 16'h0, 1'b0);
    exp = sb_a.pop_front();
    n_checks++; if (a_valid !== 1'b1 || a_inp !== exp || a_cnt !== 16'd2) begin n_fail++;
      $display("FAIL noillegal_next: got %b/%h/%0d want 1/%h/2", a_valid, a_inp, a_cnt, exp); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0;
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_full_and_drain();
    test_flush();
    test_reset_mid_hold();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
